// File: rtl/fifo_wr_arb_pkg.sv
// Shared state encoding, default word width and width helper for the FIFO write arbiter.
package fifo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int DATAWIDTH = 8;

  // Ceiling log2; returns 0 for values of 1 or less.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_if.sv
// Requester and FIFO write-side signals of the arbiter; master is the arbiter side.
interface fifo_wr_arb_if
  import fifo_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int DATAWIDTH  = fifo_pkg::DATAWIDTH,
  parameter int OWNERWIDTH = clog2(NREQ)
);

  logic [NREQ-1:0]           req;
  logic [NREQ*DATAWIDTH-1:0] req_data;
  logic [NREQ-1:0]           gnt;
  logic [NREQ-1:0]           ack;
  logic                      fifo_full;
  logic                      fifo_wr_en;
  logic [DATAWIDTH-1:0]      fifo_data_in;
  logic [OWNERWIDTH-1:0]     owner;
  logic                      busy;

  modport master (
    input  req, req_data, fifo_full,
    output gnt, ack, fifo_wr_en, fifo_data_in, owner, busy
  );

  modport slave (
    output req, req_data, fifo_full,
    input  gnt, ack, fifo_wr_en, fifo_data_in, owner, busy
  );

endinterface

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo NREQ.
module fifo_rr_pick
  import fifo_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int OWNERWIDTH = clog2(NREQ)
) (
  input  logic [NREQ-1:0]       req_i,
  input  logic [OWNERWIDTH-1:0] ptr_i,
  output logic                  valid_o,
  output logic [OWNERWIDTH-1:0] idx_o
);

  logic [NREQ-1:0] rot;
  int              off;
  int              sum;

  // Rotate so bit 0 is the requester at ptr; shifting by NREQ yields zero when ptr is 0.
  assign rot = (req_i >> ptr_i) | (req_i << (NREQ - int'(ptr_i)));

  always_comb begin
    off = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = i;
      end
    end
  end

  always_comb begin
    sum = int'(ptr_i) + off;
    if (sum >= NREQ) begin
      sum = sum - NREQ;
    end
  end

  assign valid_o = |req_i;
  assign idx_o   = OWNERWIDTH'(sum);

endmodule

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with first-word-fall-through read data.
// Writes while full and reads while empty are ignored.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATAWIDTH = fifo_pkg::DATAWIDTH,
  parameter int DEPTH     = 16,
  parameter int AW        = clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en_i,
  input  logic [DATAWIDTH-1:0] wr_dat_i,
  input  logic                 rd_en_i,
  output logic [DATAWIDTH-1:0] rd_dat_o,
  output logic                 full_o,
  output logic                 empty_o
);

  logic [DATAWIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          count_q;
  logic                 do_wr, do_rd;

  assign full_o   = (count_q == (AW+1)'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign do_wr    = wr_en_i && !full_o;
  assign do_rd    = rd_en_i && !empty_o;
  assign rd_dat_o = mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_q] <= wr_dat_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (do_wr && !do_rd) begin
        count_q <= count_q + 1'b1;
      end else if (do_rd && !do_wr) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin owner of one FIFO write port; grants bursts of up to MAX_BURST words.
// Grant one edge after request, one word per cycle, one idle bubble between owners; stalls on fifo_full.
module fifo_wr_arb
  import fifo_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int DATAWIDTH  = fifo_pkg::DATAWIDTH,
  parameter int MAX_BURST  = 4,
  parameter int OWNERWIDTH = clog2(NREQ),
  parameter int BURSTWIDTH = clog2(MAX_BURST + 1)
) (
  input  logic          clk,
  input  logic          rst,
  fifo_wr_arb_if.master bus
);

  arb_state_e            state_q, state_d;
  logic [OWNERWIDTH-1:0] owner_q, owner_d;
  logic [OWNERWIDTH-1:0] ptr_q, ptr_d;
  logic [BURSTWIDTH-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0]       gnt_q, gnt_d;
  logic [NREQ-1:0]       ack_d;
  logic [DATAWIDTH-1:0]  data_d;
  logic                  pick_vld;
  logic [OWNERWIDTH-1:0] pick_idx;
  logic                  beat, last_beat;

  fifo_rr_pick #(
    .NREQ       (NREQ),
    .OWNERWIDTH (OWNERWIDTH)
  ) u_pick (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .valid_o (pick_vld),
    .idx_o   (pick_idx)
  );

  assign beat      = (state_q == GRANT) && bus.req[owner_q] && !bus.fifo_full;
  assign last_beat = beat && (cnt_q == BURSTWIDTH'(MAX_BURST - 1));

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = GRANT;
          owner_d = pick_idx;
          gnt_d   = NREQ'(1) << pick_idx;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (beat) begin
          cnt_d = cnt_q + 1'b1;
        end
        // A full FIFO alone never releases; only a capped burst or a dropped request does.
        if (last_beat || !bus.req[owner_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
          ptr_d   = (owner_q == OWNERWIDTH'(NREQ - 1)) ? '0 : owner_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack_d  = '0;
    data_d = '0;
    if (beat) begin
      ack_d = gnt_q;
      for (int i = 0; i < NREQ; i++) begin
        if (owner_q == OWNERWIDTH'(i)) begin
          data_d = bus.req_data[i*DATAWIDTH +: DATAWIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.ack          = ack_d;
  assign bus.fifo_wr_en   = beat;
  assign bus.fifo_data_in = data_d;
  assign bus.owner        = owner_q;
  assign bus.busy         = (state_q == GRANT);

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb driving a real 16-deep sync_fifo on its write port.
module tb_fifo_wr_arb;
  import fifo_pkg::*;

  localparam int NREQ = 4;
  localparam int DW   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arb_if #(.NREQ(NREQ), .DATAWIDTH(DW), .OWNERWIDTH(2)) bus();

  logic          force_full = 1'b0;
  logic          rd_en = 1'b0;
  logic          ff_full, ff_empty;
  logic [DW-1:0] rd_dat;

  assign bus.fifo_full = ff_full | force_full;

  fifo_wr_arb #(
    .NREQ(NREQ), .DATAWIDTH(DW), .MAX_BURST(4), .OWNERWIDTH(2), .BURSTWIDTH(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  sync_fifo #(.DATAWIDTH(DW), .DEPTH(16), .AW(4)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en_i  (bus.fifo_wr_en),
    .wr_dat_i (bus.fifo_data_in),
    .rd_en_i  (rd_en),
    .rd_dat_o (rd_dat),
    .full_o   (ff_full),
    .empty_o  (ff_empty)
  );

  logic [DW-1:0]   wq [NREQ][32];
  int              head [NREQ];
  int              tail [NREQ];
  logic [DW-1:0]   rdlog [64];
  int              rd_n, ack_n;
  logic            auto_rd = 1'b0;
  logic [NREQ-1:0] s_gnt, s_ack;
  logic            s_busy, s_wr;
  logic [DW-1:0]   s_dat;
  logic [1:0]      s_own;
  int              tests_run = 0;
  int              tests_failed = 0;

  task automatic push(input int r, input logic [DW-1:0] w);
    wq[r][tail[r]] = w;
    tail[r] = tail[r] + 1;
  endtask

  task automatic drive_req();
    for (int i = 0; i < NREQ; i++) begin
      bus.req[i] = (head[i] < tail[i]);
      bus.req_data[i*DW +: DW] = (head[i] < tail[i]) ? wq[i][head[i]] : '0;
    end
  endtask

  // One cycle: sample outputs at negedge, then after the edge retire acked words.
  task automatic step();
    @(negedge clk);
    s_gnt  = bus.gnt;
    s_ack  = bus.ack;
    s_busy = bus.busy;
    s_wr   = bus.fifo_wr_en;
    s_dat  = bus.fifo_data_in;
    s_own  = bus.owner;
    if (rd_en && !ff_empty && rd_n < 64) begin
      rdlog[rd_n] = rd_dat;
      rd_n = rd_n + 1;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (s_ack[i]) begin
        head[i] = head[i] + 1;
        ack_n = ack_n + 1;
      end
    end
    drive_req();
    rd_en = auto_rd && !ff_empty;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    force_full = 1'b0;
    auto_rd = 1'b0;
    rd_en = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    drive_req();
    step();
    step();
    rst = 1'b0;
    rd_n = 0;
    ack_n = 0;
  endtask

  task automatic test_reset();
    do_reset();
    step();
    tests_run++;
    if ({s_gnt, s_ack} !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_gnt_ack: got %b expected 00000000", {s_gnt, s_ack});
    end
    tests_run++;
    if ({s_busy, s_wr, s_dat, s_own} !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h expected 000", {s_busy, s_wr, s_dat, s_own});
    end
    for (int k = 0; k < 4; k++) push(2, 8'h21 + 8'(k));
    drive_req();
    step();
    tests_run++;
    if ({s_busy, s_wr} !== 2'b00) begin
      tests_failed++;
      $display("FAIL grant_latency: got %b expected 00", {s_busy, s_wr});
    end
    step();
    tests_run++;
    if ({s_gnt, s_wr, s_dat} !== {4'b0100, 1'b1, 8'h21}) begin
      tests_failed++;
      $display("FAIL first_beat: got %h expected %h", {s_gnt, s_wr, s_dat}, {4'b0100, 1'b1, 8'h21});
    end
    step();
    #2;
    tests_run++;
    if ({bus.gnt, bus.fifo_wr_en, bus.fifo_data_in} !== {4'b0100, 1'b1, 8'h23}) begin
      tests_failed++;
      $display("FAIL mid_burst: got %h expected %h",
               {bus.gnt, bus.fifo_wr_en, bus.fifo_data_in}, {4'b0100, 1'b1, 8'h23});
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if ({bus.gnt, bus.busy, bus.fifo_wr_en, bus.ack} !== 10'h000) begin
      tests_failed++;
      $display("FAIL async_reset: got %b expected 0000000000",
               {bus.gnt, bus.busy, bus.fifo_wr_en, bus.ack});
    end
    push(1, 8'h11);
    push(3, 8'h31);
    drive_req();
    step();
    step();
    rst = 1'b0;
    step();
    tests_run++;
    if (s_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_idle: got busy=%b expected 0", s_busy);
    end
    step();
    tests_run++;
    if ({s_gnt, s_own, s_dat} !== {4'b0010, 2'd1, 8'h11}) begin
      tests_failed++;
      $display("FAIL post_reset_grant: got %h expected %h", {s_gnt, s_own, s_dat}, {4'b0010, 2'd1, 8'h11});
    end
  endtask

  task automatic test_burst_split();
    logic [13:0] exp_t [10];
    exp_t = '{{4'b0000, 2'b00, 8'h00}, {4'b0001, 2'b11, 8'h01}, {4'b0001, 2'b11, 8'h02},
              {4'b0001, 2'b11, 8'h03}, {4'b0001, 2'b11, 8'h04}, {4'b0000, 2'b00, 8'h00},
              {4'b0001, 2'b11, 8'h05}, {4'b0001, 2'b11, 8'h06}, {4'b0001, 2'b10, 8'h00},
              {4'b0000, 2'b00, 8'h00}};
    do_reset();
    for (int k = 1; k <= 6; k++) push(0, 8'(k));
    drive_req();
    for (int c = 0; c < 10; c++) begin
      step();
      tests_run++;
      if ({s_gnt, s_busy, s_wr, s_dat} !== exp_t[c]) begin
        tests_failed++;
        $display("FAIL split_cycle%0d: got %h expected %h", c, {s_gnt, s_busy, s_wr, s_dat}, exp_t[c]);
      end
    end
    auto_rd = 1'b1;
    repeat (12) step();
    tests_run++;
    if (rd_n !== 6) begin
      tests_failed++;
      $display("FAIL split_readcount: got %0d expected 6", rd_n);
    end
    for (int k = 0; k < 6 && k < rd_n; k++) begin
      tests_run++;
      if (rdlog[k] !== 8'(k + 1)) begin
        tests_failed++;
        $display("FAIL split_read%0d: got %h expected %h", k, rdlog[k], 8'(k + 1));
      end
    end
  endtask

  task automatic test_fairness();
    int nb, last_c, eo;
    logic [DW-1:0] ed;
    do_reset();
    for (int i = 0; i < NREQ; i++)
      for (int k = 0; k < 8; k++) push(i, 8'(i * 16 + k + 1));
    drive_req();
    auto_rd = 1'b1;
    nb = 0;
    last_c = 0;
    for (int c = 0; c < 200 && nb < 32; c++) begin
      step();
      if (s_wr) begin
        eo = (nb / 4) % 4;
        ed = 8'(eo * 16 + (nb / 16) * 4 + nb % 4 + 1);
        tests_run++;
        if ({s_own, s_ack, s_dat} !== {2'(eo), 4'(1 << eo), ed}) begin
          tests_failed++;
          $display("FAIL fair_beat%0d: got %h expected %h", nb, {s_own, s_ack, s_dat}, {2'(eo), 4'(1 << eo), ed});
        end
        if (nb > 0) begin
          tests_run++;
          if ((c - last_c) !== ((nb % 4 == 0) ? 2 : 1)) begin
            tests_failed++;
            $display("FAIL fair_gap%0d: got %0d expected %0d", nb, c - last_c, (nb % 4 == 0) ? 2 : 1);
          end
        end
        last_c = c;
        nb++;
      end
    end
    tests_run++;
    if (nb !== 32) begin
      tests_failed++;
      $display("FAIL fair_total: got %0d beats expected 32", nb);
    end
  endtask

  task automatic test_full_stall();
    logic [17:0] exp_t [10];
    logic [9:0]  full_t;
    exp_t = '{{4'b0000, 2'b00, 4'b0000, 8'h00}, {4'b0010, 2'b11, 4'b0010, 8'h41},
              {4'b0010, 2'b11, 4'b0010, 8'h42}, {4'b0010, 2'b10, 4'b0000, 8'h00},
              {4'b0010, 2'b10, 4'b0000, 8'h00}, {4'b0010, 2'b10, 4'b0000, 8'h00},
              {4'b0010, 2'b11, 4'b0010, 8'h43}, {4'b0010, 2'b11, 4'b0010, 8'h44},
              {4'b0000, 2'b00, 4'b0000, 8'h00}, {4'b0010, 2'b11, 4'b0010, 8'h45}};
    full_t = 10'b0000111000;
    do_reset();
    for (int k = 0; k < 5; k++) push(1, 8'h41 + 8'(k));
    drive_req();
    force_full = full_t[0];
    for (int c = 0; c < 10; c++) begin
      step();
      tests_run++;
      if ({s_gnt, s_busy, s_wr, s_ack, s_dat} !== exp_t[c]) begin
        tests_failed++;
        $display("FAIL stall_cycle%0d: got %h expected %h", c, {s_gnt, s_busy, s_wr, s_ack, s_dat}, exp_t[c]);
      end
      if (c < 9) force_full = full_t[c + 1];
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 1; k <= 20; k++) push(1, 8'(k));
    drive_req();
    repeat (40) step();
    tests_run++;
    if (ack_n !== 16) begin
      tests_failed++;
      $display("FAIL ovf_acks: got %0d expected 16", ack_n);
    end
    tests_run++;
    if ({ff_full, bus.fifo_wr_en} !== 2'b10) begin
      tests_failed++;
      $display("FAIL ovf_full: got full,wr_en=%b expected 10", {ff_full, bus.fifo_wr_en});
    end
    auto_rd = 1'b1;
    repeat (40) step();
    tests_run++;
    if ({rd_n, ack_n} !== {32'd20, 32'd20}) begin
      tests_failed++;
      $display("FAIL ovf_drain: got reads=%0d acks=%0d expected 20 and 20", rd_n, ack_n);
    end
    for (int k = 0; k < 20 && k < rd_n; k++) begin
      tests_run++;
      if (rdlog[k] !== 8'(k + 1)) begin
        tests_failed++;
        $display("FAIL ovf_read%0d: got %h expected %h", k, rdlog[k], 8'(k + 1));
      end
    end
  endtask

  task automatic test_early_drop();
    logic [13:0] exp_t [12];
    exp_t = '{{4'b0000, 2'b00, 8'h00}, {4'b0100, 2'b11, 8'h2A}, {4'b0100, 2'b10, 8'h00},
              {4'b0000, 2'b00, 8'h00}, {4'b1000, 2'b11, 8'h3A}, {4'b1000, 2'b11, 8'h3B},
              {4'b1000, 2'b10, 8'h00}, {4'b0000, 2'b00, 8'h00}, {4'b0001, 2'b11, 8'h0A},
              {4'b0001, 2'b10, 8'h00}, {4'b0000, 2'b00, 8'h00}, {4'b0010, 2'b11, 8'h1A}};
    do_reset();
    push(2, 8'h2A);
    drive_req();
    for (int c = 0; c < 12; c++) begin
      step();
      tests_run++;
      if ({s_gnt, s_busy, s_wr, s_dat} !== exp_t[c]) begin
        tests_failed++;
        $display("FAIL drop_cycle%0d: got %h expected %h", c, {s_gnt, s_busy, s_wr, s_dat}, exp_t[c]);
      end
      if (c == 2) begin
        push(3, 8'h3A);
        push(3, 8'h3B);
        push(0, 8'h0A);
        push(1, 8'h1A);
        drive_req();
      end
      if (c == 6) begin
        tests_run++;
        if (dut.ptr_q !== 2'd0) begin
          tests_failed++;
          $display("FAIL drop_ptr: got %0d expected 0", dut.ptr_q);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_burst_split();
    test_fairness();
    test_full_stall();
    test_overflow();
    test_early_drop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
